// File: rtl/rx_mcu_if.sv
// rtl/rx_mcu_if.sv - bit-stream input, config and byte-output bundle for rx_mcu
//
// Groups every rx_mcu signal except clk/rst.
//   slave  : view used by rx_mcu (consumes bits, produces config and bytes)
//   master : view used by the PHY/MAC side driving and observing the block
interface rx_mcu_if;
    logic        mcu_din_start;
    logic        mcu_din;
    logic        mcu_din_vld;
    logic        mcu_din_rdy;
    logic [3:0]  mcu_rate_con;
    logic [15:0] mcu_config_dout;
    logic        mcu_config_dout_vld;
    logic        mcu_sig_err;
    logic [7:0]  mcu_mac_dout;
    logic        mcu_mac_dout_vld;
    logic        mcu_mac_dout_last;
    logic        mcu_mac_din_rdy;
    logic        rx_end;

    modport slave (
        input  mcu_din_start, mcu_din, mcu_din_vld, mcu_mac_din_rdy,
        output mcu_din_rdy, mcu_rate_con, mcu_config_dout, mcu_config_dout_vld,
               mcu_sig_err, mcu_mac_dout, mcu_mac_dout_vld, mcu_mac_dout_last,
               rx_end
    );

    modport master (
        output mcu_din_start, mcu_din, mcu_din_vld, mcu_mac_din_rdy,
        input  mcu_din_rdy, mcu_rate_con, mcu_config_dout, mcu_config_dout_vld,
               mcu_sig_err, mcu_mac_dout, mcu_mac_dout_vld, mcu_mac_dout_last,
               rx_end
    );
endinterface

// File: rtl/rx_mcu.sv
// rtl/rx_mcu.sv - receive-side MAC control unit: SIGNAL parse and PSDU byte packing
//
// Parses the 24-bit SIGNAL field from the serial bit stream, reports RATE and
// LENGTH, drops SVC_BITS SERVICE bits, then packs LENGTH bytes LSB-first into
// a one-entry holding register toward the MAC.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : rx_mcu_if.slave
//          bit input     mcu_din_start / mcu_din / mcu_din_vld / mcu_din_rdy
//          config out    mcu_rate_con / mcu_config_dout / mcu_config_dout_vld / mcu_sig_err
//          byte output   mcu_mac_dout / _vld / _last, mcu_mac_din_rdy, rx_end
module rx_mcu #(
    parameter int SVC_BITS = 16
) (
    input  logic      clk,
    input  logic      rst,
    rx_mcu_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SIG, SVC, DATA, DONE} state_t;

    localparam logic [7:0] SIG_LAST = 8'd23;
    localparam logic [7:0] SVC_LAST = 8'(SVC_BITS - 1);

    state_t      state;
    logic [22:0] sig_sr;
    logic [7:0]  cnt;
    logic [6:0]  byte_sr;
    logic [2:0]  bit_cnt;
    logic [11:0] byte_cnt;

    logic [3:0]  rate_con;
    logic [15:0] config_dout;
    logic        config_vld;
    logic        sig_err;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_last;
    logic        rx_end;

    logic        din_rdy;
    logic        accept;
    logic        handshake;
    logic [23:0] sig_next;
    logic [7:0]  byte_next;
    logic        sig_ok;
    logic        last_byte;

    // Only the bit that would complete a byte must wait while the holding
    // register is still full, so an unaccepted byte is never overwritten.
    assign din_rdy   = (state == DATA) ?
                       ~(dout_vld & ~bus.mcu_mac_din_rdy & (bit_cnt == 3'd7)) : 1'b1;
    assign accept    = bus.mcu_din_vld & din_rdy;
    assign handshake = dout_vld & bus.mcu_mac_din_rdy;

    // Including the bit being accepted now lets the check and the byte load
    // happen on the same edge as the final bit.
    assign sig_next  = {bus.mcu_din, sig_sr};
    assign byte_next = {bus.mcu_din, byte_sr};

    // Every legal RATE code has bit0 set; parity is even over bits 0..17.
    assign sig_ok    = ~(^sig_next[17:0]) & sig_next[0] & ~sig_next[4] &
                       (sig_next[16:5] != 12'd0);

    // config_dout holds the LENGTH of the frame in progress.
    assign last_byte = ((byte_cnt + 12'd1) == config_dout[15:4]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sig_sr      <= '0;
            cnt         <= '0;
            byte_sr     <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            rate_con    <= '0;
            config_dout <= '0;
            config_vld  <= 1'b0;
            sig_err     <= 1'b0;
            dout        <= '0;
            dout_vld    <= 1'b0;
            dout_last   <= 1'b0;
            rx_end      <= 1'b0;
        end else begin
            config_vld <= 1'b0;
            sig_err    <= 1'b0;
            rx_end     <= 1'b0;

            // A load below overrides this, giving back-to-back bytes with no bubble.
            if (handshake) begin
                dout_vld  <= 1'b0;
                dout_last <= 1'b0;
            end

            if (bus.mcu_din_start) begin
                // Start (or abort-and-restart): the pending byte is dropped
                // and a bit arriving with start is SIGNAL bit 0.
                state     <= SIG;
                cnt       <= '0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                dout_vld  <= 1'b0;
                dout_last <= 1'b0;
                if (accept) begin
                    sig_sr <= sig_next[23:1];
                    cnt    <= 8'd1;
                end
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SIG: begin
                        if (accept) begin
                            sig_sr <= sig_next[23:1];
                            cnt    <= cnt + 8'd1;
                            if (cnt == SIG_LAST) begin
                                cnt <= '0;
                                if (sig_ok) begin
                                    rate_con    <= sig_next[3:0];
                                    config_dout <= {sig_next[16:5], sig_next[3:0]};
                                    config_vld  <= 1'b1;
                                    state       <= (SVC_BITS == 0) ? DATA : SVC;
                                end else begin
                                    sig_err <= 1'b1;
                                    state   <= IDLE;
                                end
                            end
                        end
                    end
                    SVC: begin
                        if (accept) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == SVC_LAST) begin
                                cnt   <= '0;
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            byte_sr <= byte_next[7:1];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                dout      <= byte_next;
                                dout_vld  <= 1'b1;
                                dout_last <= last_byte;
                                byte_cnt  <= byte_cnt + 12'd1;
                                if (last_byte) begin
                                    state <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        // Tail/pad bits are swallowed until the last byte leaves.
                        if (handshake) begin
                            rx_end <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.mcu_din_rdy         = din_rdy;
    assign bus.mcu_rate_con        = rate_con;
    assign bus.mcu_config_dout     = config_dout;
    assign bus.mcu_config_dout_vld = config_vld;
    assign bus.mcu_sig_err         = sig_err;
    assign bus.mcu_mac_dout        = dout;
    assign bus.mcu_mac_dout_vld    = dout_vld;
    assign bus.mcu_mac_dout_last   = dout_last;
    assign bus.rx_end              = rx_end;
endmodule

// File: tb/tb_rx_mcu.sv
// tb/tb_rx_mcu.sv - directed self-checking bench for rx_mcu
module tb_rx_mcu;
    logic clk;
    logic rst;

    rx_mcu_if bus ();

    rx_mcu #(.SVC_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    int cfg_cnt     = 0;
    int err_cnt     = 0;
    int rxend_cnt   = 0;
    int rdy_low_cnt = 0;
    logic [8:0] rx_q[$];

    logic       hold_prev    = 1'b0;
    logic [7:0] hold_data    = '0;
    logic       hold_last    = 1'b0;
    logic       last_hs_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev    = 1'b0;
            last_hs_prev = 1'b0;
        end else begin
            if (bus.mcu_config_dout_vld) cfg_cnt++;
            if (bus.mcu_sig_err) err_cnt++;
            if (bus.rx_end) begin
                rxend_cnt++;
                check("rx_end_after_last_hs", 32'(last_hs_prev), 32'd1);
            end
            if (hold_prev && bus.mcu_mac_dout_vld) begin
                check("hold_data", 32'(bus.mcu_mac_dout), 32'(hold_data));
                check("hold_last", 32'(bus.mcu_mac_dout_last), 32'(hold_last));
            end
            if (!bus.mcu_din_rdy) rdy_low_cnt++;
            hold_prev    = bus.mcu_mac_dout_vld & ~bus.mcu_mac_din_rdy;
            hold_data    = bus.mcu_mac_dout;
            hold_last    = bus.mcu_mac_dout_last;
            last_hs_prev = bus.mcu_mac_dout_vld & bus.mcu_mac_din_rdy & bus.mcu_mac_dout_last;
            if (bus.mcu_mac_dout_vld && bus.mcu_mac_din_rdy)
                rx_q.push_back({bus.mcu_mac_dout_last, bus.mcu_mac_dout});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [23:0] mk_sig(input logic [3:0] rate, input logic res,
                                           input logic [11:0] len, input logic flip);
        logic [23:0] s;
        s = {6'b0, 1'b0, len, res, rate};
        s[17] = (^s[16:0]) ^ flip;
        return s;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_bit(input logic b, input logic st);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        bus.mcu_din       = b;
        bus.mcu_din_vld   = 1'b1;
        bus.mcu_din_start = st;
        do begin
            @(negedge clk);
            acc = bus.mcu_din_rdy;
            @(posedge clk);
            #1;
            bus.mcu_din_start = 1'b0;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("bit_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_sig(input logic [23:0] s, input logic st, input int from);
        for (int i = from; i < 24; i++) send_bit(s[i], (i == from) ? st : 1'b0);
    endtask

    task automatic send_svc();
        for (int i = 0; i < 16; i++) send_bit(i[0], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
        bus.mcu_din_vld = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_din_rdy"},  32'(bus.mcu_din_rdy), 32'd1);
        check({pfx, "_rate_con"}, 32'(bus.mcu_rate_con), 32'd0);
        check({pfx, "_config"},   32'(bus.mcu_config_dout), 32'd0);
        check({pfx, "_cfg_vld"},  32'(bus.mcu_config_dout_vld), 32'd0);
        check({pfx, "_sig_err"},  32'(bus.mcu_sig_err), 32'd0);
        check({pfx, "_dout"},     32'(bus.mcu_mac_dout), 32'd0);
        check({pfx, "_dout_vld"}, 32'(bus.mcu_mac_dout_vld), 32'd0);
        check({pfx, "_last"},     32'(bus.mcu_mac_dout_last), 32'd0);
        check({pfx, "_rx_end"},   32'(bus.rx_end), 32'd0);
    endtask

    initial begin
        logic [23:0] s;
        logic [23:0] bad [3];
        int c0, q0, e0, r0, x0, n;

        bus.mcu_din_start   = 1'b0;
        bus.mcu_din         = 1'b0;
        bus.mcu_din_vld     = 1'b0;
        bus.mcu_mac_din_rdy = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Valid frame: RATE 1101, LENGTH 3, bytes A5 3C FF.
        c0 = cfg_cnt; q0 = rx_q.size(); e0 = err_cnt; x0 = rxend_cnt;
        bus.mcu_din_start = 1'b1;
        @(posedge clk);
        #1;
        bus.mcu_din_start = 1'b0;
        send_sig(mk_sig(4'hD, 1'b0, 12'd3, 1'b0), 1'b0, 0);
        check("t1_cfg_vld_pulse", 32'(bus.mcu_config_dout_vld), 32'd1);
        check("t1_config", 32'(bus.mcu_config_dout), 32'h003D);
        check("t1_rate_con", 32'(bus.mcu_rate_con), 32'hD);
        send_svc();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hFF);
        finish_frame();
        check("t1_cfg_count", 32'(cfg_cnt - c0), 32'd1);
        check("t1_nbytes", 32'(rx_q.size() - q0), 32'd3);
        if (rx_q.size() - q0 == 3) begin
            check("t1_byte0", 32'(rx_q[q0]),     32'h0A5);
            check("t1_byte1", 32'(rx_q[q0 + 1]), 32'h03C);
            check("t1_byte2", 32'(rx_q[q0 + 2]), 32'h1FF);
        end
        check("t1_rx_end_count", 32'(rxend_cnt - x0), 32'd1);
        check("t1_no_sig_err", 32'(err_cnt - e0), 32'd0);

        // Parity error, start arriving together with SIGNAL bit 0.
        c0 = cfg_cnt; q0 = rx_q.size(); e0 = err_cnt;
        send_sig(mk_sig(4'hD, 1'b0, 12'd3, 1'b1), 1'b1, 0);
        check("perr_sig_err_pulse", 32'(bus.mcu_sig_err), 32'd1);
        check("perr_no_cfg_vld", 32'(bus.mcu_config_dout_vld), 32'd0);
        send_svc();
        send_byte(8'h5A);
        bus.mcu_din_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("perr_rate_kept", 32'(bus.mcu_rate_con), 32'hD);
        check("perr_config_kept", 32'(bus.mcu_config_dout), 32'h003D);
        check("perr_no_bytes", 32'(rx_q.size() - q0), 32'd0);
        check("perr_no_cfg", 32'(cfg_cnt - c0), 32'd0);
        check("perr_err_count", 32'(err_cnt - e0), 32'd1);

        // RATE 0000, reserved=1, LENGTH=0 (all with correct parity).
        bad[0] = mk_sig(4'h0, 1'b0, 12'd3, 1'b0);
        bad[1] = mk_sig(4'hD, 1'b1, 12'd3, 1'b0);
        bad[2] = mk_sig(4'hD, 1'b0, 12'd0, 1'b0);
        e0 = err_cnt; c0 = cfg_cnt;
        for (int k = 0; k < 3; k++) begin
            send_sig(bad[k], 1'b1, 0);
            check($sformatf("bad%0d_sig_err", k), 32'(bus.mcu_sig_err), 32'd1);
        end
        bus.mcu_din_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bad_err_count", 32'(err_cnt - e0), 32'd3);
        check("bad_no_cfg", 32'(cfg_cnt - c0), 32'd0);
        check("bad_rate_kept", 32'(bus.mcu_rate_con), 32'hD);

        // Backpressure: LENGTH 4, MAC stalls 20 cycles after byte 1 appears.
        q0 = rx_q.size(); x0 = rxend_cnt; r0 = rdy_low_cnt;
        fork
            begin
                send_sig(mk_sig(4'hB, 1'b0, 12'd4, 1'b0), 1'b1, 0);
                check("bp_config", 32'(bus.mcu_config_dout), 32'h004B);
                send_svc();
                send_byte(8'h11);
                send_byte(8'h22);
                send_byte(8'h33);
                send_byte(8'h44);
                finish_frame();
            end
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!bus.mcu_mac_dout_vld && n < 500);
                if (!bus.mcu_mac_dout_vld) check("bp_first_byte_timeout", 32'd0, 32'd1);
                bus.mcu_mac_din_rdy = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                bus.mcu_mac_din_rdy = 1'b1;
            end
        join
        check("bp_rdy_low_cycles", 32'(rdy_low_cnt - r0), 32'd13);
        check("bp_nbytes", 32'(rx_q.size() - q0), 32'd4);
        if (rx_q.size() - q0 == 4) begin
            check("bp_byte0", 32'(rx_q[q0]),     32'h011);
            check("bp_byte1", 32'(rx_q[q0 + 1]), 32'h022);
            check("bp_byte2", 32'(rx_q[q0 + 2]), 32'h033);
            check("bp_byte3", 32'(rx_q[q0 + 3]), 32'h144);
        end
        check("bp_rx_end_count", 32'(rxend_cnt - x0), 32'd1);

        // Abort during byte 2 of a LENGTH 5 frame, then LENGTH 1 frame with 5A.
        q0 = rx_q.size(); x0 = rxend_cnt; e0 = err_cnt;
        bus.mcu_mac_din_rdy = 1'b0;
        send_sig(mk_sig(4'h7, 1'b0, 12'd5, 1'b0), 1'b1, 0);
        check("ab_config1", 32'(bus.mcu_config_dout), 32'h0057);
        send_svc();
        send_byte(8'h01);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("ab_pending_before", 32'(bus.mcu_mac_dout_vld), 32'd1);
        s = mk_sig(4'hF, 1'b0, 12'd1, 1'b0);
        send_bit(s[0], 1'b1);
        check("ab_pending_dropped", 32'(bus.mcu_mac_dout_vld), 32'd0);
        bus.mcu_mac_din_rdy = 1'b1;
        send_sig(s, 1'b0, 1);
        check("ab_cfg_vld_pulse", 32'(bus.mcu_config_dout_vld), 32'd1);
        check("ab_config2", 32'(bus.mcu_config_dout), 32'h001F);
        send_svc();
        send_byte(8'h5A);
        finish_frame();
        check("ab_nbytes", 32'(rx_q.size() - q0), 32'd1);
        if (rx_q.size() - q0 == 1) check("ab_byte", 32'(rx_q[q0]), 32'h15A);
        check("ab_rx_end_count", 32'(rxend_cnt - x0), 32'd1);
        check("ab_no_sig_err", 32'(err_cnt - e0), 32'd0);

        // Reset in the middle of DATA with a byte pending.
        bus.mcu_mac_din_rdy = 1'b0;
        send_sig(mk_sig(4'hD, 1'b0, 12'd3, 1'b0), 1'b1, 0);
        send_svc();
        send_byte(8'h77);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        bus.mcu_din_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        bus.mcu_mac_din_rdy = 1'b1;
        q0 = rx_q.size(); c0 = cfg_cnt; e0 = err_cnt; x0 = rxend_cnt;
        send_sig(mk_sig(4'hD, 1'b0, 12'd1, 1'b0), 1'b0, 0);
        send_svc();
        send_byte(8'hC3);
        finish_frame();
        check("post_rst_no_bytes", 32'(rx_q.size() - q0), 32'd0);
        check("post_rst_no_cfg", 32'(cfg_cnt - c0), 32'd0);
        check("post_rst_no_err", 32'(err_cnt - e0), 32'd0);
        check("post_rst_no_rx_end", 32'(rxend_cnt - x0), 32'd0);
        check("post_rst_rate_con", 32'(bus.mcu_rate_con), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rx_mcu.md
# rx_mcu

Receive-side MAC control unit, mirror of the transmit MCU. Takes the descrambled/decoded serial bit stream from the PHY receive chain, parses the 24-bit SIGNAL field (RATE, reserved, LENGTH, parity, tail) and reports rate and length to the MAC and the demodulator. It then discards the SERVICE bits and packs exactly LENGTH PSDU bytes, LSB-first, onto a valid/ready byte interface toward the MAC. A one-cycle end-of-packet pulse closes each frame.

## Interface
Parameters:
- SVC_BITS, 16, number of SERVICE bits discarded after SIGNAL (range 0..255).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- mcu_din_start  in  1  packet-start pulse; arms SIGNAL parsing.
- mcu_din  in  1  serial data bit.
- mcu_din_vld  in  1  mcu_din valid.
- mcu_din_rdy  out  1  bit accepted when mcu_din_vld & mcu_din_rdy.
- mcu_rate_con  out  4  decoded RATE code to the demodulator; held until the next valid SIGNAL.
- mcu_config_dout  out  16  {LENGTH[11:0], RATE[3:0]}.
- mcu_config_dout_vld  out  1  one-cycle pulse when a valid SIGNAL has been parsed.
- mcu_sig_err  out  1  one-cycle pulse when a SIGNAL is rejected.
- mcu_mac_dout  out  8  received PSDU byte.
- mcu_mac_dout_vld  out  1  byte valid.
- mcu_mac_dout_last  out  1  marks the LENGTH-th byte; qualified by vld.
- mcu_mac_din_rdy  in  1  MAC ready.
- rx_end  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- States: IDLE, SIG, SVC, DATA, DONE.
- IDLE:
  - mcu_din_rdy=1; accepted bits are discarded.
  - mcu_din_start moves to SIG and clears all counters.
- SIG: 24 accepted bits are shifted in, with bit k being the k-th accepted bit.
  - RATE = bits 3..0 (bit0 = R1).
  - Reserved = bit 4.
  - LENGTH = bits 16..5, bit 5 is LSB.
  - Parity = bit 17.
  - Tail = bits 23..18.
- SIGNAL check after the 24th bit. The SIGNAL is valid only if all of these hold:
  - XOR of bits 0..17 = 0 (even parity);
  - RATE ∈ {1101, 1111, 0101, 0111, 1001, 1011, 0001, 0011};
  - reserved = 0;
  - LENGTH ≠ 0.
  - Tail is not checked.
- Valid SIGNAL:
  - Load mcu_rate_con and mcu_config_dout.
  - Pulse mcu_config_dout_vld.
  - Go to SVC, or directly to DATA if SVC_BITS=0.
- Invalid SIGNAL: pulse mcu_sig_err and return to IDLE; mcu_rate_con and mcu_config_dout are not updated.
- SVC: accept and drop SVC_BITS bits, then go to DATA.
- DATA:
  - Bits enter an 8-bit shift register LSB-first (first bit → byte bit0).
  - Each completed byte loads a one-entry output holding register.
  - A 12-bit byte counter compares against LENGTH; the byte equal to LENGTH sets mcu_mac_dout_last.
  - After that byte loads, the state moves to DONE.
- DONE:
  - mcu_din_rdy=1; remaining tail/pad bits are discarded.
  - When the last byte handshakes: pulse rx_end, then go to IDLE.
- Backpressure in DATA: mcu_din_rdy = ~(mcu_mac_dout_vld & ~mcu_mac_din_rdy & bit_cnt==7).
  - A completed byte never overwrites an unaccepted byte.
  - In SIG and SVC, mcu_din_rdy=1.
- mcu_din_start in any non-IDLE state aborts the current packet:
  - Drop the pending output byte (vld→0).
  - Go to SIG with counters cleared.
  - No rx_end and no mcu_sig_err are generated for the aborted packet.
- Start and valid bit in the same cycle: the bit is the first SIGNAL bit.
- rst: all state returns to IDLE, all counters clear.

## Timing
- Reset values:
  - mcu_din_rdy=1
  - mcu_rate_con=0
  - mcu_config_dout=0
  - mcu_config_dout_vld=0
  - mcu_sig_err=0
  - mcu_mac_dout=0
  - mcu_mac_dout_vld=0
  - mcu_mac_dout_last=0
  - rx_end=0
- mcu_config_dout_vld / mcu_sig_err assert in the cycle after the 24th SIGNAL bit is accepted.
- Byte latency: mcu_mac_dout_vld rises the cycle after the 8th bit of the byte is accepted. It stays high, with data and last stable, until mcu_mac_din_rdy.
- Full rate: one bit per cycle is sustained with mcu_mac_din_rdy=1.
- A byte handshake and a new byte load may occur in the same cycle; the holding register takes the new byte with no bubble.
- rx_end asserts the cycle after the last-byte handshake. The state is IDLE in that same cycle, so a new mcu_din_start there is honoured.

## Test plan
- Valid frame:
  - Stimulus: RATE=1101, LENGTH=3, correct parity, tail 0, 16 SERVICE bits, data bytes A5, 3C, FF, mac_rdy=1.
  - Response: config_vld with 16'h003D, rate_con=1101, then bytes A5, 3C, FF with last only on FF, rx_end one cycle after FF is accepted.
- Parity error: same frame with bit 17 flipped → mcu_sig_err pulse, no config_vld, no bytes, state IDLE; rate_con keeps its previous value.
- Invalid fields:
  - RATE=0000 → sig_err.
  - Reserved=1 → sig_err.
  - LENGTH=0 with correct parity → sig_err.
- Backpressure:
  - Stimulus: LENGTH=4, mac_rdy low for 20 cycles after the first byte.
  - Response: mcu_din_rdy drops at bit_cnt==7 of byte 2; byte 1 is held stable; no byte lost or reordered after mac_rdy rises.
- Abort:
  - Stimulus: mcu_din_start during byte 2 of a LENGTH=5 frame, then a valid LENGTH=1 frame carrying byte 5A.
  - Response: pending byte dropped, no rx_end for the aborted frame, new config 16'h001x, byte 5A with last, rx_end.
- Reset mid-DATA: rst asserted for one cycle → all outputs return to reset values, and bits arriving afterwards without mcu_din_start produce no output.
